memfifo_bridge: RTL and testbench

Parametrised datapath between the EZ-USB streaming interface and the on-board FIFO. It handles the host→FIFO direction, packing `USB_WIDTH`-bit transfers into `FIFO_WIDTH`-bit words, and the FIFO→host direction, unpacking them again. An internal framed test-pattern generator has selectable rate, and error flags are sticky. It sits between the EZ-USB I/O module and the BRAM/SDRAM FIFO in the memfifo top level, replacing hand-written glue for a fixed 16/32-bit ratio.

---
 rtl/memfifo_pkg.sv | 19 +
 rtl/memfifo_testgen.sv | 61 ++++++
 rtl/memfifo_bridge.sv | 171 +++++++++++++++++
 tb/tb_memfifo_bridge.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memfifo_pkg.sv
// Shared definitions for the memfifo bridge: mode encodings, test-pattern
// constants and the checksum fold used by the test generator.
package memfifo_pkg;

    typedef enum logic [1:0] {
        MODE_USB  = 2'd0,
        MODE_FAST = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_SEL  = 2'd3
    } mode_e;

    localparam int unsigned CNT_STEP = 111;
    localparam int unsigned CS_INIT  = 47;

    function automatic logic [6:0] cs_fold(input logic [13:0] cs);
        return cs[6:0] ^ cs[13:7];
    endfunction

endpackage

// File: rtl/memfifo_testgen.sv
// Framed test-pattern byte generator with selectable tick rate, stall input
// and restart; one byte is offered (and consumed) whenever o_valid is high.
module memfifo_testgen #(
    parameter int unsigned RATE_DIV_W = 2,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned CNT_STEP   = 111,
    parameter int unsigned CS_INIT    = 47
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_fast,
    input  logic       i_restart,
    input  logic       i_stall,
    output logic       o_valid,
    output logic [7:0] o_byte
);
    import memfifo_pkg::*;

    localparam int unsigned IW = $clog2(FRAME_LEN);

    logic [RATE_DIV_W-1:0] r_div;
    logic [IW-1:0]         r_i;
    logic [6:0]            r_cnt;
    logic [13:0]           r_cs;

    logic w_tick;
    logic w_last;
    logic w_sync;

    always_comb begin
        w_tick  = i_fast || (r_div == '0);
        w_last  = (r_i == IW'(FRAME_LEN - 1));
        w_sync  = r_i[0] || (r_i == IW'(FRAME_LEN - 2));
        o_valid = i_en && !i_restart && !i_stall && w_tick;
        o_byte  = w_last ? {1'b0, cs_fold(r_cs)} : {w_sync, r_cnt};
    end

    // Lost ticks are simply dropped: state only advances on a consumed byte.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_restart) begin
            r_div <= '0;
            r_i   <= '0;
            r_cnt <= '0;
            r_cs  <= 14'(CS_INIT);
        end else begin
            r_div <= r_div + 1'b1;
            if (o_valid) begin
                r_i <= r_i + 1'b1;
                if (w_last) begin
                    r_cs <= 14'(CS_INIT);
                end else begin
                    r_cnt <= r_cnt + 7'(CNT_STEP);
                    // checksum accumulates the bytes exactly as emitted
                    r_cs  <= r_cs + {6'd0, o_byte};
                end
            end
        end
    end

endmodule

// File: rtl/memfifo_bridge.sv
// EZ-USB <-> FIFO datapath: packs USB words (or test-pattern bytes) into FIFO
// words and unpacks FIFO words back into USB words; sticky error flags.
module memfifo_bridge #(
    parameter int unsigned USB_WIDTH  = 16,
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned RATE_DIV_W = 2,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned CNT_STEP   = memfifo_pkg::CNT_STEP,
    parameter int unsigned CS_INIT    = memfifo_pkg::CS_INIT
) (
    input  logic                  ifclk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  fast_sel,
    input  logic [USB_WIDTH-1:0]  usb_do,
    input  logic                  usb_do_valid,
    output logic                  usb_do_ready,
    output logic [FIFO_WIDTH-1:0] fifo_di,
    output logic                  fifo_wren,
    input  logic                  fifo_full,
    input  logic                  fifo_wrerr,
    input  logic [FIFO_WIDTH-1:0] fifo_do,
    input  logic                  fifo_empty,
    output logic                  fifo_rden,
    input  logic                  fifo_rderr,
    output logic [USB_WIDTH-1:0]  usb_di,
    output logic                  usb_di_valid,
    input  logic                  usb_di_ready,
    output logic                  wrerr_sticky,
    output logic                  rderr_sticky,
    output logic [31:0]           words_written
);
    import memfifo_pkg::*;

    localparam int unsigned R      = FIFO_WIDTH / USB_WIDTH;
    localparam int unsigned NBYTES = FIFO_WIDTH / 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned CNT_W  = $clog2(R + 1);

    logic [1:0]            r_mode;
    logic [IDX_W-1:0]      r_idx;
    logic [FIFO_WIDTH-1:0] r_acc;
    logic                  r_pend;
    logic [FIFO_WIDTH-1:0] r_pend_data;
    logic [31:0]           r_words;
    logic                  r_wrerr;
    logic                  r_rderr;
    logic [FIFO_WIDTH-1:0] r_lanes;
    logic [CNT_W-1:0]      r_lcnt;

    logic                  w_mode_chg;
    logic                  w_fast;
    logic                  w_usb_acc;
    logic                  w_gen_acc;
    logic [7:0]            w_gen_byte;
    logic [IDX_W-1:0]      w_idx_cur;
    logic [FIFO_WIDTH-1:0] w_acc_cur;
    logic [FIFO_WIDTH-1:0] w_acc_nxt;
    logic                  w_fill;
    logic                  w_last;
    logic                  w_wr;
    logic                  w_take;
    logic                  w_load;

    assign w_mode_chg = (mode != r_mode);
    assign w_fast     = (mode == MODE_FAST) || ((mode == MODE_SEL) && fast_sel);

    memfifo_testgen #(
        .RATE_DIV_W (RATE_DIV_W),
        .FRAME_LEN  (FRAME_LEN),
        .CNT_STEP   (CNT_STEP),
        .CS_INIT    (CS_INIT)
    ) u_testgen (
        .i_clk     (ifclk),
        .i_reset   (reset),
        .i_en      (mode != MODE_USB),
        .i_fast    (w_fast),
        .i_restart (w_mode_chg),
        .i_stall   (r_pend),
        .o_valid   (w_gen_acc),
        .o_byte    (w_gen_byte)
    );

    assign usb_do_ready = (mode == MODE_USB) && !reset && !r_pend;
    assign w_usb_acc    = usb_do_valid && usb_do_ready;

    // A mode change discards the partial word; a word accepted in that same
    // cycle starts a fresh word in lane 0.
    always_comb begin
        w_idx_cur = w_mode_chg ? '0 : r_idx;
        w_acc_cur = w_mode_chg ? '0 : r_acc;
        w_acc_nxt = w_acc_cur;
        w_fill    = 1'b0;
        w_last    = 1'b0;
        if (w_usb_acc) begin
            w_acc_nxt[int'(w_idx_cur) * USB_WIDTH +: USB_WIDTH] = usb_do;
            w_fill = 1'b1;
            w_last = (w_idx_cur == IDX_W'(R - 1));
        end else if (w_gen_acc) begin
            w_acc_nxt[int'(w_idx_cur) * 8 +: 8] = w_gen_byte;
            w_fill = 1'b1;
            w_last = (w_idx_cur == IDX_W'(NBYTES - 1));
        end
    end

    assign w_wr          = r_pend && !fifo_full && !reset;
    assign fifo_wren     = w_wr;
    assign fifo_di       = r_pend_data;
    assign words_written = r_words;
    assign wrerr_sticky  = r_wrerr;
    assign rderr_sticky  = r_rderr;

    always_ff @(posedge ifclk) begin
        if (reset) begin
            r_mode      <= MODE_USB;
            r_idx       <= '0;
            r_acc       <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_words     <= '0;
            r_wrerr     <= 1'b0;
            r_rderr     <= 1'b0;
        end else begin
            r_mode <= mode;
            if (w_fill && w_last) begin
                r_idx       <= '0;
                r_acc       <= '0;
                r_pend      <= 1'b1;
                r_pend_data <= w_acc_nxt;
            end else begin
                r_idx <= w_fill ? (w_idx_cur + IDX_W'(1)) : w_idx_cur;
                r_acc <= w_acc_nxt;
                if (w_wr) begin
                    r_pend <= 1'b0;
                end
            end
            if (w_wr) begin
                r_words <= r_words + 32'd1;
            end
            if (fifo_wrerr) begin
                r_wrerr <= 1'b1;
            end
            if (fifo_rderr) begin
                r_rderr <= 1'b1;
            end
        end
    end

    // Unpacker: refill in the same cycle the last lane is taken, so FIFO words
    // stream back-to-back.
    assign usb_di       = r_lanes[USB_WIDTH-1:0];
    assign usb_di_valid = (r_lcnt != '0);
    assign w_take       = usb_di_valid && usb_di_ready;
    assign w_load       = ((r_lcnt == '0) || ((r_lcnt == CNT_W'(1)) && w_take))
                          && !fifo_empty && !reset;
    assign fifo_rden    = w_load;

    always_ff @(posedge ifclk) begin
        if (reset) begin
            r_lanes <= '0;
            r_lcnt  <= '0;
        end else if (w_load) begin
            r_lanes <= fifo_do;
            r_lcnt  <= CNT_W'(R);
        end else if (w_take) begin
            r_lanes <= r_lanes >> USB_WIDTH;
            r_lcnt  <= r_lcnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_memfifo_bridge.sv
// Directed bench for memfifo_bridge (16/32-bit) with write and USB-read
// scoreboards plus an independent model of the framed test pattern.
module tb_memfifo_bridge;

    localparam logic [6:0]  STEP = 7'd111;
    localparam logic [13:0] CSI  = 14'd47;

    logic        ifclk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        fast_sel = 1'b0;
    logic [15:0] usb_do = '0;
    logic        usb_do_valid = 1'b0;
    logic        usb_do_ready;
    logic [31:0] fifo_di;
    logic        fifo_wren;
    logic        fifo_full = 1'b0;
    logic        fifo_wrerr = 1'b0;
    logic [31:0] fifo_do = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rden;
    logic        fifo_rderr = 1'b0;
    logic [15:0] usb_di;
    logic        usb_di_valid;
    logic        usb_di_ready = 1'b0;
    logic        wrerr_sticky;
    logic        rderr_sticky;
    logic [31:0] words_written;

    always #5 ifclk = ~ifclk;

    memfifo_bridge #(
        .USB_WIDTH  (16),
        .FIFO_WIDTH (32),
        .RATE_DIV_W (2),
        .FRAME_LEN  (16),
        .CNT_STEP   (111),
        .CS_INIT    (47)
    ) dut (
        .ifclk         (ifclk),
        .reset         (reset),
        .mode          (mode),
        .fast_sel      (fast_sel),
        .usb_do        (usb_do),
        .usb_do_valid  (usb_do_valid),
        .usb_do_ready  (usb_do_ready),
        .fifo_di       (fifo_di),
        .fifo_wren     (fifo_wren),
        .fifo_full     (fifo_full),
        .fifo_wrerr    (fifo_wrerr),
        .fifo_do       (fifo_do),
        .fifo_empty    (fifo_empty),
        .fifo_rden     (fifo_rden),
        .fifo_rderr    (fifo_rderr),
        .usb_di        (usb_di),
        .usb_di_valid  (usb_di_valid),
        .usb_di_ready  (usb_di_ready),
        .wrerr_sticky  (wrerr_sticky),
        .rderr_sticky  (rderr_sticky),
        .words_written (words_written)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_wr = 0;
    int n_rden = 0;
    int cyc = 0;
    int wr_cyc = 0;
    int prev_wr_cyc = 0;
    int base = 0;
    logic [31:0] last_wr = '0;
    logic [31:0] wr_q[$];
    logic [15:0] rd_q[$];

    int          m_i;
    logic [6:0]  m_cnt;
    logic [13:0] m_cs;
    logic [6:0]  m_fold;
    logic [6:0]  fold0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle; outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge ifclk);
        cyc++;
        if (fifo_wren === 1'b1) begin
            n_wr++;
            prev_wr_cyc = wr_cyc;
            wr_cyc = cyc;
            last_wr = fifo_di;
            check("write_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) check("fifo_di", fifo_di, wr_q.pop_front());
        end
        if (usb_di_valid === 1'b1 && usb_di_ready === 1'b1) begin
            check("usb_read_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) check("usb_di", 32'(usb_di), 32'(rd_q.pop_front()));
        end
        if (fifo_rden === 1'b1) n_rden++;
        @(posedge ifclk);
        #1;
    endtask

    task automatic wait_wr(input int target, input int budget, input string tag);
        int k = 0;
        while (n_wr < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(n_wr >= target), 32'd1);
    endtask

    task automatic model_reset();
        m_i = 0;
        m_cnt = '0;
        m_cs = CSI;
    endtask

    task automatic model_byte(output logic [7:0] b);
        logic sync;
        if (m_i == 15) begin
            m_fold = m_cs[6:0] ^ m_cs[13:7];
            b = {1'b0, m_fold};
            m_cs = CSI;
            m_i = 0;
        end else begin
            sync = m_i[0] || (m_i == 14);
            b = {sync, m_cnt};
            m_cs = m_cs + {6'd0, b};
            m_cnt = m_cnt + STEP;
            m_i++;
        end
    endtask

    task automatic push_gen(input int n);
        logic [31:0] w;
        logic [7:0]  b;
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 4; k++) begin
                model_byte(b);
                w[k*8 +: 8] = b;
            end
            wr_q.push_back(w);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_usb_do_ready"}, 32'(usb_do_ready), 32'd0);
        check({tag, "_fifo_wren"}, 32'(fifo_wren), 32'd0);
        check({tag, "_fifo_di"}, fifo_di, 32'd0);
        check({tag, "_fifo_rden"}, 32'(fifo_rden), 32'd0);
        check({tag, "_usb_di"}, 32'(usb_di), 32'd0);
        check({tag, "_usb_di_valid"}, 32'(usb_di_valid), 32'd0);
        check({tag, "_wrerr"}, 32'(wrerr_sticky), 32'd0);
        check({tag, "_rderr"}, 32'(rderr_sticky), 32'd0);
        check({tag, "_words"}, words_written, 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // packing 0x0302, 0x0504 -> 0x05040302
        check("ready_idle", 32'(usb_do_ready), 32'd1);
        wr_q.push_back(32'h0504_0302);
        usb_do_valid = 1'b1;
        usb_do = 16'h0302;
        tick();
        usb_do = 16'h0504;
        tick();
        usb_do_valid = 1'b0;
        check("pend_ready_low", 32'(usb_do_ready), 32'd0);
        check("wren_next_cycle", 32'(fifo_wren), 32'd1);
        tick();
        check("words_written_1", words_written, 32'd1);
        check("wren_one_cycle", 32'(fifo_wren), 32'd0);

        // full stall for 10 cycles
        fifo_full = 1'b1;
        usb_do_valid = 1'b1;
        usb_do = 16'h1111;
        tick();
        usb_do = 16'h2222;
        tick();
        usb_do = 16'h3333;
        wr_q.push_back(32'h2222_1111);
        for (int i = 0; i < 10; i++) begin
            check("full_ready_low", 32'(usb_do_ready), 32'd0);
            check("full_di_stable", fifo_di, 32'h2222_1111);
            check("full_no_wren", 32'(fifo_wren), 32'd0);
            tick();
        end
        fifo_full = 1'b0;
        usb_do_valid = 1'b0;
        #1;
        check("wren_on_release", 32'(fifo_wren), 32'd1);
        tick();
        check("words_written_2", words_written, 32'd2);

        // unpacking 0xAABBCCDD with ready stuck high
        usb_di_ready = 1'b1;
        fifo_do = 32'hAABB_CCDD;
        fifo_empty = 1'b0;
        #1;
        check("rden_comb", 32'(fifo_rden), 32'd1);
        rd_q.push_back(16'hCCDD);
        rd_q.push_back(16'hAABB);
        tick();
        fifo_empty = 1'b1;
        check("unp_valid", 32'(usb_di_valid), 32'd1);
        check("unp_lane0", 32'(usb_di), 32'h0000_CCDD);
        tick();
        check("unp_lane1", 32'(usb_di), 32'h0000_AABB);
        tick();
        check("unp_drained", 32'(usb_di_valid), 32'd0);
        check("unp_one_rden", 32'(n_rden), 32'd1);

        // hold while usb_di_ready is low
        usb_di_ready = 1'b0;
        fifo_do = 32'h1234_5678;
        fifo_empty = 1'b0;
        tick();
        fifo_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 32'(usb_di_valid), 32'd1);
            check("hold_data", 32'(usb_di), 32'h0000_5678);
            tick();
        end
        rd_q.push_back(16'h5678);
        rd_q.push_back(16'h1234);
        usb_di_ready = 1'b1;
        tick();
        tick();
        check("hold_drained", 32'(usb_di_valid), 32'd0);

        // two FIFO words back to back, no bubble
        fifo_do = 32'hAAAA_5555;
        fifo_empty = 1'b0;
        rd_q.push_back(16'h5555);
        rd_q.push_back(16'hAAAA);
        rd_q.push_back(16'h5555);
        rd_q.push_back(16'hAAAA);
        tick();
        tick();
        tick();
        fifo_empty = 1'b1;
        check("nobubble_valid", 32'(usb_di_valid), 32'd1);
        check("nobubble_data", 32'(usb_di), 32'h0000_5555);
        tick();
        tick();
        check("nobubble_drained", 32'(usb_di_valid), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("rden_total", 32'(n_rden), 32'd4);

        // sticky errors
        fifo_wrerr = 1'b1;
        tick();
        fifo_wrerr = 1'b0;
        check("wrerr_set", 32'(wrerr_sticky), 32'd1);
        check("rderr_clear", 32'(rderr_sticky), 32'd0);
        repeat (5) tick();
        check("wrerr_sticky", 32'(wrerr_sticky), 32'd1);
        fifo_rderr = 1'b1;
        tick();
        fifo_rderr = 1'b0;
        tick();
        check("rderr_sticky", 32'(rderr_sticky), 32'd1);

        // test pattern, fast (4 bytes plus one stall cycle per word)
        model_reset();
        push_gen(4);
        fold0 = m_fold;
        push_gen(4);
        base = n_wr;
        mode = 2'd1;
        wait_wr(base + 1, 40, "m1_first_write");
        check("m1_word0", last_wr, 32'hCD5E_EF00);
        wait_wr(base + 4, 40, "m1_frame_written");
        check("m1_byte14_sync", 32'(last_wr[23]), 32'd1);
        check("m1_byte15_fold", 32'(last_wr[31:24]), 32'({1'b0, fold0}));
        check("m1_interval", 32'(wr_cyc - prev_wr_cyc), 32'd5);
        mode = 2'd0;
        repeat (3) tick();
        wr_q.delete();

        // test pattern, slow: one byte every 4 cycles
        model_reset();
        push_gen(4);
        base = n_wr;
        mode = 2'd2;
        wait_wr(base + 3, 120, "m2_writes");
        check("m2_interval", 32'(wr_cyc - prev_wr_cyc), 32'd16);
        mode = 2'd0;
        repeat (3) tick();
        wr_q.delete();

        // mode 3 with fast_sel behaves as fast
        model_reset();
        push_gen(4);
        fast_sel = 1'b1;
        base = n_wr;
        mode = 2'd3;
        wait_wr(base + 3, 40, "m3_writes");
        check("m3_interval", 32'(wr_cyc - prev_wr_cyc), 32'd5);
        mode = 2'd0;
        fast_sel = 1'b0;
        repeat (3) tick();
        wr_q.delete();

        // mode switch mid-word drops the partial USB word
        usb_do_valid = 1'b1;
        usb_do = 16'hBEEF;
        tick();
        usb_do_valid = 1'b0;
        model_reset();
        push_gen(2);
        base = n_wr;
        mode = 2'd1;
        wait_wr(base + 1, 40, "sw_write");
        check("sw_word0", last_wr, 32'hCD5E_EF00);
        mode = 2'd0;
        repeat (3) tick();
        wr_q.delete();

        // reset after one USB word: nothing written, all outputs zero
        usb_do_valid = 1'b1;
        usb_do = 16'h7777;
        tick();
        usb_do_valid = 1'b0;
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        tick();
        wr_q.push_back(32'h9999_8888);
        usb_do_valid = 1'b1;
        usb_do = 16'h8888;
        tick();
        usb_do = 16'h9999;
        tick();
        usb_do_valid = 1'b0;
        repeat (2) tick();
        check("post_reset_words", words_written, 32'd1);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
